ahb_burst_master: RTL and testbench
===================================

// Module: ahb_burst_master
// PURPOSE
//  Parametrised AHB-Lite master. Executes 1..MAX_BEATS-beat INCR bursts issued on a simple T* command port.
//  Address and data phases are fully pipelined and stretched by Hready wait states; Hresp errors abort the burst.
//  Sits between test/CPU-side command logic and the AHB bus, ahead of the AHB-to-APB bridge.
// PARAMETERS
//  AW         32  address width
//  DW         32  data width; one of 8/16/32/64; Hsize = log2(DW/8), beat stride = DW/8 bytes
//  MAX_BEATS  16  maximum beats per burst
//  LEN_W      5   width of Tlen; must satisfy 2**LEN_W > MAX_BEATS
// PORTS
//  HCLK     in   1      clock
//  Hrst     in   1      reset, synchronous, active-high
//  Tstart   in   1      command request; accepted only while Tbusy=0
//  Twrite   in   1      1=write burst, 0=read burst; sampled at accept
//  Taddr    in   AW     start address, DW/8-aligned; sampled at accept
//  Tlen     in   LEN_W  beat count; 0 is treated as 1, values >MAX_BEATS are clamped to MAX_BEATS
//  Twdata   in   DW     write data; consumed in the cycle Twreq=1
//  Twreq    out  1      combinational: current write address phase completes this cycle, Twdata taken
//  Trdata   out  DW     read data, registered
//  Trvalid  out  1      1-cycle strobe, Trdata valid
//  Tbusy    out  1      burst in progress
//  Tdone    out  1      1-cycle strobe, burst finished
//  Terr     out  1      1-cycle strobe with Tdone when the burst aborted on ERROR
//  Haddr    out  AW     address
//  Htrans   out  2      00 IDLE, 10 NONSEQ, 11 SEQ (BUSY=01 never driven)
//  Hen      out  1      Htrans!=IDLE
//  Hwrite   out  1      direction
//  Hsize    out  3      constant log2(DW/8)
//  Hburst   out  3      000 SINGLE (len=1), 001 INCR (len>1)
//  Hwdata   out  DW     write data, registered
//  Hrdata   in   DW     read data
//  Hready   in   1      1=current phase completes
//  Hresp    in   1      0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset values: Haddr=0, Htrans=IDLE, Hen=0, Hwrite=0, Hburst=0, Hwdata=0, Trdata=0, Trvalid=0, Tdone=0,
//   Terr=0, Tbusy=0, state=IDLE. Reset mid-burst abandons the transfer: no Tdone and no further T* strobes.
//  FSM states:
//   IDLE:  Tstart -> latch command; next cycle Htrans=NONSEQ, Haddr=Taddr, Tbusy=1 -> ADDR.
//   ADDR:  address phase pending, no data phase outstanding.
//   PIPE:  address of beat n+1 overlaps data phase of beat n.
//   LAST:  data phase of final beat only; Htrans=IDLE.
//   ERR:   second cycle of the ERROR response.
//  Advance: a phase completes only on an edge with Hready=1.
//   While Hready=0: Haddr, Htrans, Hwrite and Hwdata hold.
//  Each completed address phase: Haddr += DW/8 (mod 2**AW) and Htrans=SEQ while addresses remain; else IDLE.
//  1KB boundary: a beat whose address has bits[9:0]==0 and is not the first beat is issued as NONSEQ;
//   Hburst stays INCR.
//  Write: Twreq=1 in the cycle a write address phase completes; Hwdata<=Twdata on that edge.
//  Read: data phase completing with Hready=1, Hresp=0 -> Trdata<=Hrdata, Trvalid=1 next cycle.
//  Completion: Tdone=1 the cycle after the final data phase completes; Tbusy drops in the same cycle.
//   Earliest next accept is that cycle.
//  Error: data phase with Hresp=1, Hready=0 -> next cycle Htrans=IDLE, remaining beats cancelled, state ERR.
//   In ERR, Hready=1 -> Tdone=1, Terr=1; no Trvalid for the errored beat; return to IDLE.
//  Tstart while Tbusy=1 is ignored, not queued.
//  Minimum latency, single beat with no waits: accept edge -> address phase -> data phase -> Tdone (3 cycles).
// TESTING
//  Single write, Taddr=0x100, Tlen=1, Twdata=0xDEADBEEF, Hready=1:
//   NONSEQ 0x100, Hburst=000, Hwdata=0xDEADBEEF one cycle later, Tdone 3 cycles after accept.
//  4-beat read at 0x2000, Hready low 2 cycles on beat 2:
//   Haddr 0x2000/04/08/0C with NONSEQ,SEQ,SEQ,SEQ; Haddr held during wait; 4 Trvalid in order; one Tdone.
//  4-beat write at 0x3F8:
//   Htrans NONSEQ,SEQ,NONSEQ(0x400),SEQ; Twreq pulses exactly 4 times.
//  Error on beat 2 of 8-beat read:
//   Hresp=1/Hready=0 then Hresp=1/Hready=1 -> Htrans=IDLE next cycle, 1 Trvalid, Tdone=Terr=1, Tbusy=0.
//  Hrst=1 mid-burst on beat 3:
//   all outputs at reset values after the next edge; no Tdone; a new Tstart then runs normally.
//  Tstart pulsed while Tbusy=1, plus Tlen=0 and Tlen=31:
//   busy pulse ignored; Tlen=0 runs 1 beat; Tlen=31 runs 16 beats.

Source files
------------

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: runs 1..MAX_BEATS-beat INCR bursts requested on the T* command port,
// with pipelined address/data phases, Hready wait states and ERROR abort.
module ahb_burst_master #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned LEN_W     = 5
) (
  input  logic             HCLK,
  input  logic             Hrst,
  input  logic             Tstart,
  input  logic             Twrite,
  input  logic [AW-1:0]    Taddr,
  input  logic [LEN_W-1:0] Tlen,
  input  logic [DW-1:0]    Twdata,
  output logic             Twreq,
  output logic [DW-1:0]    Trdata,
  output logic             Trvalid,
  output logic             Tbusy,
  output logic             Tdone,
  output logic             Terr,
  output logic [AW-1:0]    Haddr,
  output logic [1:0]       Htrans,
  output logic             Hen,
  output logic             Hwrite,
  output logic [2:0]       Hsize,
  output logic [2:0]       Hburst,
  output logic [DW-1:0]    Hwdata,
  input  logic [DW-1:0]    Hrdata,
  input  logic             Hready,
  input  logic             Hresp
);

  localparam int unsigned Stride      = DW / 8;
  localparam logic [2:0]  SizeCode    = 3'($clog2(DW / 8));
  localparam logic [1:0]  TransIdle   = 2'b00;
  localparam logic [1:0]  TransNonseq = 2'b10;
  localparam logic [1:0]  TransSeq    = 2'b11;

  typedef enum logic [2:0] {StIdle, StAddr, StPipe, StLast, StErr} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    haddr_q, haddr_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d;
  logic [2:0]       hburst_q, hburst_d;
  logic [DW-1:0]    hwdata_q, hwdata_d;
  logic [DW-1:0]    trdata_q, trdata_d;
  logic             trvalid_q, trvalid_d;
  logic             tdone_q, tdone_d;
  logic             terr_q, terr_d;
  logic             tbusy_q, tbusy_d;
  // Addresses still to issue after the one currently on the bus.
  logic [LEN_W-1:0] rem_q, rem_d;

  logic [LEN_W-1:0] eff_len;
  logic [AW-1:0]    next_addr;
  logic             in_data, data_ok, addr_done;

  always_comb begin
    if (Tlen == '0) begin
      eff_len = LEN_W'(1);
    end else if (Tlen > LEN_W'(MAX_BEATS)) begin
      eff_len = LEN_W'(MAX_BEATS);
    end else begin
      eff_len = Tlen;
    end
  end

  assign next_addr = haddr_q + AW'(Stride);
  assign in_data   = (state_q == StPipe) || (state_q == StLast);
  assign data_ok   = in_data && Hready && !Hresp;
  // An erroring data phase in PIPE cancels the overlapping address phase.
  assign addr_done = Hready && ((state_q == StAddr) || ((state_q == StPipe) && !Hresp));
  assign Twreq     = addr_done && hwrite_q;

  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hburst_d  = hburst_q;
    hwdata_d  = hwdata_q;
    trdata_d  = trdata_q;
    tbusy_d   = tbusy_q;
    rem_d     = rem_q;
    trvalid_d = 1'b0;
    tdone_d   = 1'b0;
    terr_d    = 1'b0;

    if (Twreq) begin
      hwdata_d = Twdata;
    end
    if (data_ok && !hwrite_q) begin
      trdata_d  = Hrdata;
      trvalid_d = 1'b1;
    end
    if (addr_done) begin
      if (rem_q != '0) begin
        haddr_d  = next_addr;
        htrans_d = (next_addr[9:0] == 10'd0) ? TransNonseq : TransSeq;
        rem_d    = rem_q - LEN_W'(1);
      end else begin
        htrans_d = TransIdle;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (Tstart) begin
          haddr_d  = Taddr;
          htrans_d = TransNonseq;
          hwrite_d = Twrite;
          hburst_d = (eff_len > LEN_W'(1)) ? 3'b001 : 3'b000;
          rem_d    = eff_len - LEN_W'(1);
          tbusy_d  = 1'b1;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (Hready) begin
          state_d = (rem_q != '0) ? StPipe : StLast;
        end
      end
      StPipe, StLast: begin
        if (Hresp && !Hready) begin
          htrans_d = TransIdle;
          state_d  = StErr;
        end else if (Hready) begin
          if (Hresp || (state_q == StLast)) begin
            htrans_d = TransIdle;
            tdone_d  = 1'b1;
            terr_d   = Hresp;
            tbusy_d  = 1'b0;
            state_d  = StIdle;
          end else begin
            state_d = (rem_q != '0) ? StPipe : StLast;
          end
        end
      end
      StErr: begin
        if (Hready) begin
          tdone_d = 1'b1;
          terr_d  = 1'b1;
          tbusy_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (Hrst) begin
      state_q   <= StIdle;
      haddr_q   <= '0;
      htrans_q  <= TransIdle;
      hwrite_q  <= 1'b0;
      hburst_q  <= 3'b000;
      hwdata_q  <= '0;
      trdata_q  <= '0;
      trvalid_q <= 1'b0;
      tdone_q   <= 1'b0;
      terr_q    <= 1'b0;
      tbusy_q   <= 1'b0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hburst_q  <= hburst_d;
      hwdata_q  <= hwdata_d;
      trdata_q  <= trdata_d;
      trvalid_q <= trvalid_d;
      tdone_q   <= tdone_d;
      terr_q    <= terr_d;
      tbusy_q   <= tbusy_d;
      rem_q     <= rem_d;
    end
  end

  assign Haddr   = haddr_q;
  assign Htrans  = htrans_q;
  assign Hen     = (htrans_q != TransIdle);
  assign Hwrite  = hwrite_q;
  assign Hsize   = SizeCode;
  assign Hburst  = hburst_q;
  assign Hwdata  = hwdata_q;
  assign Trdata  = trdata_q;
  assign Trvalid = trvalid_q;
  assign Tdone   = tdone_q;
  assign Terr    = terr_q;
  assign Tbusy   = tbusy_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Scoreboard bench for ahb_burst_master: directed bursts against a scripted AHB slave,
// expected bus beats and T-side responses queued by the stimulus and popped by a monitor.
module tb_ahb_burst_master;

  logic        HCLK = 1'b0;
  logic        Hrst, Tstart, Twrite;
  logic [31:0] Taddr, Twdata;
  logic [4:0]  Tlen;
  logic        Twreq, Trvalid, Tbusy, Tdone, Terr;
  logic [31:0] Trdata, Haddr, Hwdata, Hrdata;
  logic [1:0]  Htrans;
  logic        Hen, Hwrite, Hready, Hresp;
  logic [2:0]  Hsize, Hburst;

  localparam logic [31:0] RdMask = 32'hA5A5_A5A5;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  burst;
  } addr_t;

  typedef struct {
    logic        is_done;
    logic [31:0] data;
    logic        err;
  } resp_t;

  addr_t       exp_addr[$];
  resp_t       exp_resp[$];
  logic [31:0] exp_wdata[$];
  logic [31:0] wsrc[$];

  int n_tests = 0;
  int n_fail  = 0;
  int twreq_cnt = 0;
  int stall_at = -1;
  int stall_n  = 0;
  int err_at   = -1;

  always #5 HCLK = ~HCLK;

  ahb_burst_master dut (
    .HCLK    (HCLK),
    .Hrst    (Hrst),
    .Tstart  (Tstart),
    .Twrite  (Twrite),
    .Taddr   (Taddr),
    .Tlen    (Tlen),
    .Twdata  (Twdata),
    .Twreq   (Twreq),
    .Trdata  (Trdata),
    .Trvalid (Trvalid),
    .Tbusy   (Tbusy),
    .Tdone   (Tdone),
    .Terr    (Terr),
    .Haddr   (Haddr),
    .Htrans  (Htrans),
    .Hen     (Hen),
    .Hwrite  (Hwrite),
    .Hsize   (Hsize),
    .Hburst  (Hburst),
    .Hwdata  (Hwdata),
    .Hrdata  (Hrdata),
    .Hready  (Hready),
    .Hresp   (Hresp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  task automatic push_a(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [2:0] b);
    addr_t e;
    e.addr = a; e.trans = t; e.wr = w; e.burst = b;
    exp_addr.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] d);
    resp_t r;
    r.is_done = 1'b0; r.data = d; r.err = 1'b0;
    exp_resp.push_back(r);
  endtask

  task automatic push_done(input logic e);
    resp_t r;
    r.is_done = 1'b1; r.data = '0; r.err = e;
    exp_resp.push_back(r);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_haddr"},   Haddr, 32'h0);
    chk({tag, "_htrans"},  32'(Htrans), 32'h0);
    chk({tag, "_hen"},     32'(Hen), 32'h0);
    chk({tag, "_hwrite"},  32'(Hwrite), 32'h0);
    chk({tag, "_hburst"},  32'(Hburst), 32'h0);
    chk({tag, "_hsize"},   32'(Hsize), 32'h2);
    chk({tag, "_hwdata"},  Hwdata, 32'h0);
    chk({tag, "_trdata"},  Trdata, 32'h0);
    chk({tag, "_trvalid"}, 32'(Trvalid), 32'h0);
    chk({tag, "_tdone"},   32'(Tdone), 32'h0);
    chk({tag, "_terr"},    32'(Terr), 32'h0);
    chk({tag, "_tbusy"},   32'(Tbusy), 32'h0);
  endtask

  // Issues one command and waits for Tdone; lat = cycles from accept edge to Tdone.
  // pulse_at > 0 re-asserts Tstart with a bogus command at that cycle of the burst.
  task automatic run_burst(input logic wr, input logic [31:0] addr, input logic [4:0] len,
                           input int pulse_at, output int lat);
    @(negedge HCLK); #1;
    Tstart = 1'b1; Twrite = wr; Taddr = addr; Tlen = len;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge HCLK); #1;
      Tstart = (i == pulse_at);
      if (i == pulse_at) begin
        Taddr = 32'h0000_BAD0; Twrite = ~wr; Tlen = 5'd3;
      end
      if (Tdone) begin
        lat = i;
        break;
      end
    end
    Tstart = 1'b0;
    if (lat < 0) fail_evt("tdone_timeout");
  endtask

  // Scripted slave: tracks the data phase, inserts waits/errors, supplies Hrdata and Twdata.
  initial begin
    logic        rec_rst, rec_hready, dvalid;
    logic [1:0]  rec_trans;
    logic [31:0] rec_addr, daddr;
    int          dbeat, wcnt;
    rec_rst = 1'b1; rec_hready = 1'b1; rec_trans = 2'b00; rec_addr = '0;
    dvalid = 1'b0; daddr = '0; dbeat = 0; wcnt = 0;
    Hready = 1'b1; Hresp = 1'b0; Hrdata = '0; Twdata = '0;
    forever begin
      @(negedge HCLK);
      if (rec_rst) begin
        dvalid = 1'b0; dbeat = 0; wcnt = 0;
      end else if (rec_hready) begin
        if (dvalid) dbeat++;
        dvalid = (rec_trans != 2'b00);
        daddr  = rec_addr;
        wcnt   = 0;
      end else begin
        wcnt++;
      end
      if (Tdone) dbeat = 0;
      Hresp  = 1'b0;
      Hready = 1'b1;
      if (dvalid && dbeat == err_at) begin
        Hresp  = 1'b1;
        Hready = (wcnt != 0);
      end else if (dvalid && dbeat == stall_at && wcnt < stall_n) begin
        Hready = 1'b0;
      end
      Hrdata = daddr ^ RdMask;
      Twdata = (wsrc.size() != 0) ? wsrc[0] : 32'h0;
      #2;
      rec_rst = Hrst; rec_hready = Hready; rec_trans = Htrans; rec_addr = Haddr;
      if (Twreq === 1'b1 && !Hrst && wsrc.size() != 0) void'(wsrc.pop_front());
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a bus beat or a T-side strobe.
  initial begin
    logic        m_idle_chk, m_hold_chk, m_wd_chk;
    logic [31:0] m_addr;
    logic [1:0]  m_trans;
    addr_t       ea;
    resp_t       er;
    logic [31:0] ew;
    m_idle_chk = 1'b0; m_hold_chk = 1'b0; m_wd_chk = 1'b0; m_addr = '0; m_trans = '0;
    forever begin
      @(negedge HCLK); #3;
      if (m_idle_chk) chk("err_htrans_idle", 32'(Htrans), 32'h0);
      if (m_hold_chk) begin
        chk("hold_haddr", Haddr, m_addr);
        chk("hold_htrans", 32'(Htrans), 32'(m_trans));
      end
      if (m_wd_chk) begin
        if (exp_wdata.size() == 0) fail_evt("hwdata_extra");
        else begin
          ew = exp_wdata.pop_front();
          chk("hwdata", Hwdata, ew);
        end
      end
      if (!Hrst && Htrans != 2'b00 && Hready) begin
        if (exp_addr.size() == 0) fail_evt("addr_phase_extra");
        else begin
          ea = exp_addr.pop_front();
          chk("haddr", Haddr, ea.addr);
          chk("htrans", 32'(Htrans), 32'(ea.trans));
          chk("hwrite", 32'(Hwrite), 32'(ea.wr));
          chk("hburst", 32'(Hburst), 32'(ea.burst));
          chk("hen", 32'(Hen), 32'h1);
        end
      end
      if (Twreq === 1'b1 && !Hrst) twreq_cnt++;
      if (Trvalid) begin
        if (exp_resp.size() == 0 || exp_resp[0].is_done) fail_evt("trvalid_extra");
        else begin
          er = exp_resp.pop_front();
          chk("trdata", Trdata, er.data);
        end
      end
      if (Tdone) begin
        if (exp_resp.size() == 0 || !exp_resp[0].is_done) fail_evt("tdone_extra");
        else begin
          er = exp_resp.pop_front();
          chk("terr", 32'(Terr), 32'(er.err));
          chk("tbusy_at_done", 32'(Tbusy), 32'h0);
        end
      end
      if (Terr && !Tdone) fail_evt("terr_without_tdone");
      m_idle_chk = !Hrst && Hresp && !Hready;
      m_hold_chk = !Hrst && !Hready && !Hresp && (Htrans != 2'b00);
      m_wd_chk   = !Hrst && (Twreq === 1'b1);
      m_addr     = Haddr;
      m_trans    = Htrans;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, t0;
    Hrst = 1'b1; Tstart = 1'b0; Twrite = 1'b0; Taddr = '0; Tlen = '0;
    repeat (3) @(negedge HCLK);
    #1;
    check_reset("reset");
    Hrst = 1'b0;

    // Single write, minimum latency.
    wsrc.push_back(32'hDEAD_BEEF);
    exp_wdata.push_back(32'hDEAD_BEEF);
    push_a(32'h100, 2'b10, 1'b1, 3'b000);
    push_done(1'b0);
    run_burst(1'b1, 32'h100, 5'd1, 0, lat);
    chk("single_latency", 32'(lat), 32'd3);

    // 4-beat read, two wait states on beat 2.
    stall_at = 1; stall_n = 2;
    push_a(32'h2000, 2'b10, 1'b0, 3'b001);
    push_a(32'h2004, 2'b11, 1'b0, 3'b001);
    push_a(32'h2008, 2'b11, 1'b0, 3'b001);
    push_a(32'h200C, 2'b11, 1'b0, 3'b001);
    push_rd(32'hA5A5_85A5);
    push_rd(32'hA5A5_85A1);
    push_rd(32'hA5A5_85AD);
    push_rd(32'hA5A5_85A9);
    push_done(1'b0);
    run_burst(1'b0, 32'h2000, 5'd4, 0, lat);
    stall_at = -1;

    // 4-beat write across the 1KB boundary.
    wsrc = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    exp_wdata = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    push_a(32'h3F8, 2'b10, 1'b1, 3'b001);
    push_a(32'h3FC, 2'b11, 1'b1, 3'b001);
    push_a(32'h400, 2'b10, 1'b1, 3'b001);
    push_a(32'h404, 2'b11, 1'b1, 3'b001);
    push_done(1'b0);
    t0 = twreq_cnt;
    run_burst(1'b1, 32'h3F8, 5'd4, 0, lat);
    chk("twreq_count", 32'(twreq_cnt - t0), 32'd4);

    // ERROR on beat 2 of an 8-beat read.
    err_at = 1;
    push_a(32'h500, 2'b10, 1'b0, 3'b001);
    push_a(32'h504, 2'b11, 1'b0, 3'b001);
    push_rd(32'hA5A5_A0A5);
    push_done(1'b1);
    run_burst(1'b0, 32'h500, 5'd8, 0, lat);
    err_at = -1;

    // Reset during the address phase of beat 4 of an 8-beat write.
    for (int i = 0; i < 8; i++) wsrc.push_back(32'h6000_0000 + 32'(i));
    exp_wdata = '{32'h6000_0000, 32'h6000_0001, 32'h6000_0002};
    push_a(32'h600, 2'b10, 1'b1, 3'b001);
    push_a(32'h604, 2'b11, 1'b1, 3'b001);
    push_a(32'h608, 2'b11, 1'b1, 3'b001);
    @(negedge HCLK); #1;
    Tstart = 1'b1; Twrite = 1'b1; Taddr = 32'h600; Tlen = 5'd8;
    @(negedge HCLK); #1;
    Tstart = 1'b0;
    repeat (2) @(negedge HCLK);
    @(negedge HCLK); #1;
    Hrst = 1'b1;
    @(negedge HCLK); #1;
    check_reset("midrst");
    Hrst = 1'b0;
    wsrc.delete();
    repeat (4) @(negedge HCLK);

    push_a(32'h700, 2'b10, 1'b0, 3'b000);
    push_rd(32'hA5A5_A2A5);
    push_done(1'b0);
    run_burst(1'b0, 32'h700, 5'd1, 0, lat);

    // Tstart while busy must be ignored.
    stall_at = 0; stall_n = 3;
    push_a(32'h800, 2'b10, 1'b0, 3'b001);
    push_a(32'h804, 2'b11, 1'b0, 3'b001);
    push_rd(32'hA5A5_ADA5);
    push_rd(32'hA5A5_ADA1);
    push_done(1'b0);
    run_burst(1'b0, 32'h800, 5'd2, 2, lat);
    stall_at = -1;

    // Tlen=0 runs one beat.
    push_a(32'h900, 2'b10, 1'b0, 3'b000);
    push_rd(32'hA5A5_ACA5);
    push_done(1'b0);
    run_burst(1'b0, 32'h900, 5'd0, 0, lat);

    // Tlen=31 clamps to 16 beats.
    for (int i = 0; i < 16; i++) begin
      push_a(32'h1000 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'b001);
      push_rd((32'h1000 + 32'(4 * i)) ^ RdMask);
    end
    push_done(1'b0);
    run_burst(1'b0, 32'h1000, 5'd31, 0, lat);

    repeat (4) @(negedge HCLK);
    #1;
    chk("exp_addr_left", 32'(exp_addr.size()), 32'd0);
    chk("exp_resp_left", 32'(exp_resp.size()), 32'd0);
    chk("exp_wdata_left", 32'(exp_wdata.size()), 32'd0);
    chk("idle_tbusy", 32'(Tbusy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
